// File: rtl/data_memory_lsu.sv
// data_memory_lsu: single-port data memory with a load/store front end.
// Byte-addressed little-endian access of byte, halfword or full word, with
// sign/zero extension on loads, fault detection, one-cycle response latency,
// and a hardware clear sequence that zeroes every word after reset or on clr.
//
// Ports
//   clk     sole clock, rising edge
//   rst_n   asynchronous active-low reset
//   clr     one-cycle pulse requesting a full-memory clear
//   req     access request valid
//   we      1 = store, 0 = load
//   size    00 byte, 01 halfword, 10 full word, 11 illegal
//   uns     load extension: 1 = zero-extend, 0 = sign-extend
//   a       byte address
//   wd      store data, right-aligned
//   ready   request accepted when req & ready
//   rvalid  one-cycle response strobe, cycle after acceptance
//   rd      load result (0 for stores, faults and idle cycles)
//   err     accepted request faulted, qualified by rvalid
module data_memory_lsu #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         req,
  input  logic         we,
  input  logic [1:0]   size,
  input  logic         uns,
  input  logic [31:0]  a,
  input  logic [W-1:0] wd,
  output logic         ready,
  output logic         rvalid,
  output logic [W-1:0] rd,
  output logic         err
);

  localparam int unsigned NB    = W / 8;
  localparam int unsigned OFFW  = $clog2(NB);
  localparam int unsigned IDXW  = $clog2(DEPTH);
  localparam logic [31:0] LIMIT = 32'(DEPTH * NB);
  localparam logic [IDXW-1:0] LAST_K = IDXW'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t          state;
  logic [IDXW-1:0] k;

  logic [W-1:0] mem [DEPTH];

  logic [OFFW-1:0] off;
  logic [IDXW-1:0] idx;
  logic            accept;
  logic            fault;
  logic [NB-1:0]   lanes;
  logic [W-1:0]    wd_aligned;
  logic [W-1:0]    word_rd;
  logic [W-1:0]    shifted;
  logic [W-1:0]    load_val;

  assign off    = a[OFFW-1:0];
  assign idx    = a[OFFW +: IDXW];
  assign accept = req & ready;

  // Byte-lane mask and fault decode for the presented request
  always_comb begin
    fault = 1'b0;
    lanes = '0;
    case (size)
      2'b00: lanes = NB'(1) << off;
      2'b01: begin
        lanes = NB'(3) << off;
        fault = a[0];
      end
      2'b10: begin
        lanes = '1;
        fault = (off != '0);
      end
      default: fault = 1'b1;
    endcase
    if (a >= LIMIT) fault = 1'b1;
  end

  // Store data moved up to the addressed lanes
  assign wd_aligned = wd << {off, 3'b000};

  // Load path: array read is combinational, so a store committed on the
  // previous edge is already visible to a load accepted this cycle.
  assign word_rd = mem[idx];
  assign shifted = word_rd >> {off, 3'b000};

  always_comb begin
    load_val = shifted;
    case (size)
      2'b00: load_val = uns ? W'(shifted[7:0])
                            : {{(W-8){shifted[7]}}, shifted[7:0]};
      2'b01: load_val = uns ? W'(shifted[15:0])
                            : {{(W-16){shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Control FSM with registered ready decode and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CLEAR;
      k      <= '0;
      ready  <= 1'b0;
      rvalid <= 1'b0;
      rd     <= '0;
      err    <= 1'b0;
    end else begin
      rvalid <= accept;
      err    <= accept & fault;
      rd     <= (accept && !we && !fault) ? load_val : '0;
      case (state)
        CLEAR: begin
          if (k == LAST_K) begin
            state <= IDLE;
            ready <= 1'b1;
            k     <= '0;
          end else begin
            k <= k + IDXW'(1);
          end
        end
        IDLE: begin
          // An accepted request in this cycle still completes via the
          // response registers above; clr only redirects the FSM.
          if (clr) begin
            state <= CLEAR;
            ready <= 1'b0;
            k     <= '0;
          end
        end
        default: begin
          state <= CLEAR;
          ready <= 1'b0;
          k     <= '0;
        end
      endcase
    end
  end

  // Memory array: not reset; zeroed word by word while in CLEAR
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[k] <= '0;
    end else if (accept && we && !fault) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (lanes[b]) mem[idx][b*8 +: 8] <= wd_aligned[b*8 +: 8];
      end
    end
  end

endmodule

// File: doc/data_memory_lsu.md
DATA_MEMORY_LSU -- requirements
Module: data_memory_lsu

Interface
REQ-001 SHALL provide parameter W, default 32: data word width in bits; power of two, >= 32.
REQ-002 SHALL provide parameter DEPTH, default 64: number of words; power of two, >= 2.
REQ-003 SHALL provide CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL provide RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide CLR  input  1  one-cycle pulse requesting a full-memory clear.
REQ-006 SHALL provide REQ  input  1  access request valid.
REQ-007 SHALL provide WE  input  1  1 = store, 0 = load.
REQ-008 SHALL provide SIZE  input  2  00 byte, 01 halfword (16 b), 10 full word (W b), 11 illegal.
REQ-009 SHALL provide UNS  input  1  load extension: 1 = zero-extend, 0 = sign-extend.
REQ-010 SHALL provide A  input  32  byte address, little-endian.
REQ-011 SHALL provide WD  input  W  store data, right-aligned (byte in WD[7:0], half in WD[15:0]).
REQ-012 SHALL provide READY  output  1  request accepted this cycle when REQ and READY are both 1.
REQ-013 SHALL provide RVALID  output  1  response strobe for an accepted request.
REQ-014 SHALL provide RD  output  W  load result, extended to W.
REQ-015 SHALL provide ERR  output  1  accepted request faulted; qualified by RVALID.

Function
REQ-016 Byte offset SHALL be A[log2(W/8)-1:0]; word index SHALL be the next log2(DEPTH) bits of A.
REQ-017 Request SHALL fault if A >= DEPTH*W/8, or SIZE = 11, or halfword with A[0] = 1, or full word with nonzero byte offset.
REQ-018 Store without fault SHALL write only the addressed byte lanes at the accepting edge; all other lanes keep their value.
REQ-019 Faulting store SHALL leave memory unchanged.
REQ-020 Load SHALL select the addressed bytes, shift them to bit 0, then sign- or zero-extend per UNS.
REQ-021 Full-word load SHALL ignore UNS.
REQ-022 Faulting load SHALL return RD = 0.
REQ-023 RVALID SHALL pulse for exactly one cycle, on the cycle after acceptance, for both loads and stores.
REQ-024 ERR SHALL be valid on the RVALID cycle and 0 otherwise.
REQ-025 For a store response, RD SHALL be 0.
REQ-026 RD and ERR SHALL be registered and SHALL hold 0 when RVALID = 0.
REQ-027 Throughput SHALL be one request per cycle, with no response backpressure.
REQ-028 A load accepted the cycle after a store to the same word SHALL return the stored data.
REQ-029 FSM SHALL have states CLEAR and IDLE.
REQ-030 READY SHALL be 1 only in IDLE and SHALL be a registered state decode.
REQ-031 CLEAR SHALL write 0 to word index k, k = 0..DEPTH-1, one word per cycle, then go to IDLE: exactly DEPTH cycles.
REQ-032 CLR in IDLE SHALL enter CLEAR on the next edge with k = 0.
REQ-033 CLR while already in CLEAR SHALL be ignored and SHALL NOT restart k.
REQ-034 CLR together with an accepted REQ SHALL complete that request normally (response next cycle), then enter CLEAR.
REQ-035 REQ while READY = 0 SHALL be ignored: no write, no response.

Reset
REQ-036 RST_N = 0 SHALL immediately force state CLEAR, k = 0, READY = 0, RVALID = 0, RD = 0, ERR = 0.
REQ-037 Memory array SHALL NOT be reset directly; it SHALL be zeroed by the CLEAR sequence after RST_N rises.
REQ-038 Reset during an outstanding response or a clear SHALL drop that response or clear; the full clear SHALL restart from k = 0.

Verification (W=32, DEPTH=64)
REQ-039 Release RST_N -> READY = 0 for 64 cycles, then 1; a load of every word returns 0, ERR = 0.
REQ-040 Store word 0x8899AABB at A=0x10; load byte A=0x13 with UNS=0 -> RD = 0xFFFFFF88; with UNS=1 -> RD = 0x00000088.
REQ-041 Store half 0x1234 at A=0x12 over 0x8899AABB; load word A=0x10 -> RD = 0x1234AABB.
REQ-042 Load half A=0x11 -> ERR = 1, RD = 0; store to A=0x100 -> ERR = 1, memory unchanged; SIZE = 11 -> ERR = 1.
REQ-043 Back-to-back store word 0xDEADBEEF at A=0x20, then load A=0x20 on the next cycle -> RVALID on 2 consecutive cycles, second RD = 0xDEADBEEF.
REQ-044 CLR with an accepted store at A=0x04 -> store response next cycle, READY = 0 for 64 cycles; a later load at A=0x04 -> 0. RST_N pulse mid-clear -> clear restarts, 64 cycles.
